// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address constants
//   - write_type encoding (csr_wt_e)
//   - mstatus bit positions
//   - mcause exception codes
//   - csr_apply(): combines the old CSR value with bus data for a write/set/clear
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

    // RV32 base, I extension.
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_wt_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [4:0] MCAUSE_FETCH_FAULT   = 5'd1;
    localparam logic [4:0] MCAUSE_ILLEGAL_INSTR = 5'd2;
    localparam logic [4:0] MCAUSE_BREAKPOINT    = 5'd3;
    localparam logic [4:0] MCAUSE_MISALIGNED    = 5'd4;
    localparam logic [4:0] MCAUSE_LOAD_FAULT    = 5'd5;
    localparam logic [4:0] MCAUSE_STORE_FAULT   = 5'd7;
    localparam logic [4:0] MCAUSE_ECALL_M       = 5'd11;

    function automatic logic [31:0] csr_apply(input csr_wt_e     wt,
                                              input logic [31:0] old_v,
                                              input logic [31:0] wdata);
        case (wt)
            CSR_RW:  return wdata;
            CSR_RS:  return old_v | wdata;
            CSR_RC:  return old_v & ~wdata;
            default: return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: bus between the control unit (master) and the CSR file (slave).
//   addr[11:0]       CSR address (forced to mepc during mret)
//   bus[31:0]        write data, or faulting PC during a trap
//   read, write      strobes; read also qualifies ret
//   write_type[1:0]  00 nop, 01 write, 10 set, 11 clear
//   trap, trap_cause trap taken this cycle and its exception code
//   ret              mret in flight (level)
//   csr_out[31:0]    combinational read data
//   invalid          unimplemented address or write to read-only space
interface csr_file_if;
    logic [11:0] addr;
    logic [31:0] bus;
    logic        read;
    logic        write;
    logic [1:0]  write_type;
    logic        trap;
    logic [4:0]  trap_cause;
    logic        ret;
    logic [31:0] csr_out;
    logic        invalid;

    modport master (
        output addr, bus, read, write, write_type, trap, trap_cause, ret,
        input  csr_out, invalid
    );

    modport slave (
        input  addr, bus, read, write, write_type, trap, trap_cause, ret,
        output csr_out, invalid
    );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: free-running 64-bit mcycle counter.
//   clk, rst_n  clock and asynchronous active-low reset
//   wr_lo_i     replace bits [31:0] with wdata_i this cycle
//   wr_hi_i     replace bits [63:32] with wdata_i this cycle
//   wdata_i     replacement half
//   count_o     current count
// A half write suppresses the increment for that cycle so software sees
// exactly the value it wrote.
module csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);
    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 64'd1;
        if (wr_lo_i) begin
            count_d = {count_q[63:32], wdata_i};
        end else if (wr_hi_i) begin
            count_d = {wdata_i, count_q[31:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the multi-cycle RV32I control unit.
//   clk  system clock, all updates on the rising edge
//   rst  asynchronous active-low reset
//   bif  csr_file_if.slave (address, write data, strobes, trap/ret, read data, invalid)
// Parameters: HART_ID (mhartid value), MTVEC_ADDR (fixed trap vector).
// Optional build macro CSR_COUNTERS_EN adds mcycle/mcycleh (B00/B80, writable)
// and cycle/cycleh (C00/C80, read-only); without it those addresses are
// unimplemented.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MTVEC_ADDR = 32'h4
) (
    input  logic      clk,
    input  logic      rst,
    csr_file_if.slave bif
);

    // Only MIE and MPIE are stored; MPP is hardwired to machine mode.
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [4:0]  mcause_q,   mcause_d;

    logic [31:0] rdata;
    logic        addr_ok;
    logic        wr_en;
    logic [31:0] wr_val;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic        cyc_wr_lo;
    logic        cyc_wr_hi;
`endif

    function automatic logic [31:0] mstatus_word(input logic mie, input logic mpie);
        logic [31:0] w;
        w = '0;
        w[MSTATUS_MIE]  = mie;
        w[MSTATUS_MPIE] = mpie;
        w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return w;
    endfunction

    // Read decode: purely combinational, also active during reset.
    always_comb begin
        rdata   = '0;
        addr_ok = 1'b1;
        case (bif.addr)
            CSR_MSTATUS:  rdata = mstatus_word(mstatus_mie_q, mstatus_mpie_q);
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = MTVEC_ADDR;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = {27'b0, mcause_q};
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP:      rdata = '0;
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:   rdata = '0;
            CSR_MHARTID:  rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,
            CSR_CYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:   rdata = mcycle[63:32];
`endif
            default:      addr_ok = 1'b0;
        endcase
    end

    // The 11 prefix is the architectural read-only region.
    assign bif.invalid = !addr_ok || (bif.write && (bif.addr[11:10] == 2'b11));
    assign bif.csr_out = rdata;

    // The old value used for set/clear is the current read data of the target.
    assign wr_en  = bif.write && !bif.invalid && !bif.trap;
    assign wr_val = csr_apply(csr_wt_e'(bif.write_type), rdata, bif.bus);

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mtval_d        = mtval_q;
        mcause_d       = mcause_q;

        if (bif.trap) begin
            // Trap wins over any write and over ret in the same cycle.
            mepc_d         = {bif.bus[31:2], 2'b00};
            mcause_d       = bif.trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (wr_en) begin
                case (bif.addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = wr_val[MSTATUS_MIE];
                        mstatus_mpie_d = wr_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_d      = wr_val;
                    CSR_MSCRATCH: mscratch_d = wr_val;
                    CSR_MEPC:     mepc_d     = {wr_val[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_d   = wr_val[4:0];
                    CSR_MTVAL:    mtval_d    = wr_val;
                    default:      ;
                endcase
            end
            // ret is held as a level for several cycles; read marks the single
            // cycle in which the interrupt stack is popped.
            if (bif.ret && bif.read) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mtval_q        <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mtval_q        <= mtval_d;
            mcause_q       <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    assign cyc_wr_lo = wr_en && (bif.addr == CSR_MCYCLE);
    assign cyc_wr_hi = wr_en && (bif.addr == CSR_MCYCLEH);

    csr_counter u_counter (
        .clk     (clk),
        .rst_n   (rst),
        .wr_lo_i (cyc_wr_lo),
        .wr_hi_i (cyc_wr_hi),
        .wdata_i (wr_val),
        .count_o (mcycle)
    );
`endif

endmodule

// File: tb/tb_csr_file.sv
`timescale 1ns/1ps
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [31:0] HART = 32'h0000_0005;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_file_if bif();

    csr_file #(.HART_ID(HART), .MTVEC_ADDR(32'h4)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Stored word per writable CSR address; m_mask says which bits a CSR keeps.
    logic [31:0] m_reg [0:4095];
    logic [63:0] m_cycle = '0;

    function automatic logic [31:0] m_mask(input logic [11:0] a);
        case (a)
            12'h300:                   return 32'h0000_0088;
            12'h304, 12'h340, 12'h343: return 32'hFFFF_FFFF;
            12'h341:                   return 32'hFFFF_FFFC;
            12'h342:                   return 32'h0000_001F;
            default:                   return 32'h0;
        endcase
    endfunction

    function automatic bit m_valid(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hC00, 12'hC80: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_invalid(input logic [11:0] a, input logic wr);
        return !m_valid(a) || (wr && a[11:10] == 2'b11);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_reg[12'h300] | 32'h0000_1800;
            12'h301: return 32'h4000_0100;
            12'h305: return 32'h0000_0004;
            12'h304, 12'h340, 12'h341, 12'h342, 12'h343: return m_reg[a];
            12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [11:0] a;
        logic [31:0] v;
        logic [31:0] ms;
        logic [63:0] nc;
        if (!rst) begin
            m_reg[12'h300] <= '0;
            m_reg[12'h304] <= '0;
            m_reg[12'h340] <= '0;
            m_reg[12'h341] <= '0;
            m_reg[12'h342] <= '0;
            m_reg[12'h343] <= '0;
            m_cycle        <= '0;
        end else begin
            a  = bif.addr;
            ms = m_reg[12'h300];
            nc = m_cycle + 64'd1;
            if (bif.trap) begin
                m_reg[12'h341] <= bif.bus & 32'hFFFF_FFFC;
                m_reg[12'h342] <= {27'b0, bif.trap_cause};
                m_reg[12'h300] <= ms[3] ? 32'h80 : 32'h0;
            end else begin
                if (bif.write && !m_invalid(a, 1'b1)) begin
                    case (bif.write_type)
                        2'b01:   v = bif.bus;
                        2'b10:   v = m_read(a) | bif.bus;
                        2'b11:   v = m_read(a) & ~bif.bus;
                        default: v = m_read(a);
                    endcase
                    if (m_mask(a) != 32'h0) m_reg[a] <= v & m_mask(a);
`ifdef CSR_COUNTERS_EN
                    if (a == 12'hB00) nc = {m_cycle[63:32], v};
                    if (a == 12'hB80) nc = {v, m_cycle[31:0]};
`endif
                end
                if (bif.ret && bif.read)
                    m_reg[12'h300] <= (ms[7] ? 32'h8 : 32'h0) | 32'h80;
            end
            m_cycle <= nc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_csr_out", bif.csr_out, m_read(bif.addr));
        check("model_invalid", {31'b0, bif.invalid}, {31'b0, m_invalid(bif.addr, bif.write)});
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input logic [11:0] a, input logic [31:0] b, input logic rd,
                       input logic wr, input logic [1:0] wt, input logic tr,
                       input logic [4:0] c, input logic rt);
        bif.addr = a; bif.bus = b; bif.read = rd; bif.write = wr;
        bif.write_type = wt; bif.trap = tr; bif.trap_cause = c; bif.ret = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string n, input logic [31:0] exp);
        @(negedge clk);
        check(n, bif.csr_out, exp);
    endtask

    task automatic rd(input string n, input logic [11:0] a, input logic [31:0] exp);
        drv(a, 32'h0, 1'b1, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b0);
        peek(n, exp);
        tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] b, input logic [1:0] wt);
        drv(a, b, 1'b0, 1'b1, wt, 1'b0, 5'd0, 1'b0);
        tick();
    endtask

    initial begin
        drv(12'h300, 32'h0, 1'b0, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b0);
        tick();
        peek("reset_mstatus", 32'h0000_1800);
        tick();
        rst = 1'b1;

        rd("mstatus", 12'h300, 32'h0000_1800);
        rd("misa",    12'h301, 32'h4000_0100);
        drv(12'hF14, 32'h0, 1'b1, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("mhartid", bif.csr_out, HART);
        check("mhartid_inv", {31'b0, bif.invalid}, 32'h0);
        tick();

        wr(12'h340, 32'hA5A5_A5A5, CSR_RW);
        wr(12'h340, 32'h0000_000F, CSR_RS);
        wr(12'h340, 32'h0000_00A0, CSR_RC);
        rd("mscratch_rw_rs_rc", 12'h340, 32'hA5A5_A50F);

        drv(12'h7C0, 32'h0, 1'b1, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("unimpl_out", bif.csr_out, 32'h0);
        check("unimpl_inv", {31'b0, bif.invalid}, 32'h1);
        tick();
        drv(12'hF11, 32'hFFFF_FFFF, 1'b0, 1'b1, CSR_RW, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("ro_write_inv", {31'b0, bif.invalid}, 32'h1);
        tick();
        rd("mvendorid_after_write", 12'hF11, 32'h0);

        wr(12'h300, 32'h0000_0008, CSR_RS);
        rd("mstatus_mie_set", 12'h300, 32'h0000_1808);
        drv(12'h300, 32'h0000_1237, 1'b0, 1'b0, CSR_NOP, 1'b1, MCAUSE_ILLEGAL_INSTR, 1'b0);
        tick();
        rd("trap_mepc",    12'h341, 32'h0000_1234);
        rd("trap_mcause",  12'h342, 32'h0000_0002);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        drv(12'h341, 32'h0, 1'b1, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b1);
        peek("ret_mepc", 32'h0000_1234);
        tick();
        rd("ret_mstatus", 12'h300, 32'h0000_1888);

        wr(12'h300, 32'h0000_0080, CSR_RC);
        rd("mstatus_mpie_clr", 12'h300, 32'h0000_1808);
        drv(12'h300, 32'h0, 1'b0, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            peek("ret_no_read", 32'h0000_1808);
            tick();
        end
        rd("ret_no_read_after", 12'h300, 32'h0000_1808);

        // Trap and set-bits write to mepc together: trap value must win.
        drv(12'h341, 32'h0000_0100, 1'b0, 1'b1, CSR_RS, 1'b1, MCAUSE_ECALL_M, 1'b0);
        tick();
        rd("trap_vs_write_mepc",   12'h341, 32'h0000_0100);
        rd("trap_vs_write_mcause", 12'h342, 32'h0000_000B);
        rd("trap_vs_write_mstat",  12'h300, 32'h0000_1880);

        wr(12'h341, 32'hFFFF_FFFF, CSR_RW);
        rd("mepc_align", 12'h341, 32'hFFFF_FFFC);
        wr(12'h342, 32'hFFFF_FFFF, CSR_RW);
        rd("mcause_width", 12'h342, 32'h0000_001F);
        wr(12'h305, 32'hFFFF_FFFF, CSR_RW);
        rd("mtvec_warl", 12'h305, 32'h0000_0004);
        wr(12'h301, 32'h0, CSR_RW);
        rd("misa_ro", 12'h301, 32'h4000_0100);
        wr(12'h344, 32'hFFFF_FFFF, CSR_RW);
        rd("mip_ro", 12'h344, 32'h0);

        drv(12'h340, 32'h1234_5678, 1'b1, 1'b1, CSR_RW, 1'b0, 5'd0, 1'b0);
        peek("rw_same_cycle_old", 32'hA5A5_A50F);
        tick();
        rd("rw_same_cycle_new", 12'h340, 32'h1234_5678);

        wr(12'h304, 32'h0000_0888, CSR_RW);
        wr(12'h343, 32'hCAFE_F00D, CSR_RW);
        rd("mie", 12'h304, 32'h0000_0888);
        rd("mtval", 12'h343, 32'hCAFE_F00D);

        // Asynchronous reset mid-cycle: state clears without a clock edge.
        drv(12'h340, 32'h0, 1'b1, 1'b0, CSR_NOP, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1; check("async_rst_mscratch", bif.csr_out, 32'h0);
        bif.addr = 12'h304; #1; check("async_rst_mie",     bif.csr_out, 32'h0);
        bif.addr = 12'h343; #1; check("async_rst_mtval",   bif.csr_out, 32'h0);
        bif.addr = 12'h341; #1; check("async_rst_mepc",    bif.csr_out, 32'h0);
        bif.addr = 12'h342; #1; check("async_rst_mcause",  bif.csr_out, 32'h0);
        bif.addr = 12'h300; #1; check("async_rst_mstatus", bif.csr_out, 32'h0000_1800);
        tick();
        rst = 1'b1;
        rd("post_rst_mscratch", 12'h340, 32'h0);
        rd("post_rst_mhartid",  12'hF14, HART);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
